// File: rtl/seg_display_if.sv
// Bundle between the recorder control logic and the two-digit display scheduler.
// master drives mode/time/speed and reads the display value; slave is the scheduler.
interface seg_display_if;
  logic [1:0] i_mode;
  logic [5:0] i_rec_sec;
  logic [5:0] i_play_sec;
  logic       i_speed_vld;
  logic [3:0] i_speed;
  logic [5:0] o_hex;
  logic       o_blank;
  logic [1:0] o_src;

  modport master (
    output i_mode, i_rec_sec, i_play_sec, i_speed_vld, i_speed,
    input  o_hex, o_blank, o_src
  );

  modport slave (
    input  i_mode, i_rec_sec, i_play_sec, i_speed_vld, i_speed,
    output o_hex, o_blank, o_src
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares the two-digit display between record time, play time (blinking in pause) and a timed speed overlay.
// Optional macro SEG_SAT_EN clamps time-source values above 31 to 31.
module seg_display_scheduler #(
  parameter int unsigned OVERLAY_CYC = 50000000,
  parameter int unsigned BLINK_HALF  = 25000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic          i_clk,
  input  logic          i_rst,
  seg_display_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TIME      = 3'd1,
    S_PAUSE_ON  = 3'd2,
    S_PAUSE_OFF = 3'd3,
    S_OVERLAY   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] OVL_LOAD   = CNT_W'(OVERLAY_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       speed_q, speed_d;
  logic [CNT_W-1:0] ovl_q, ovl_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic [5:0]       hex_q, hex_d;
  logic             blank_q, blank_d;
  logic [1:0]       src_q, src_d;
  logic             speed_ok_s;
  state_t           target_s;

  function automatic logic [5:0] time_val(input logic [5:0] v);
`ifdef SEG_SAT_EN
    return (v > 6'd31) ? 6'd31 : v;
`else
    return v;
`endif
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    ovl_d      = ovl_q;
    blink_d    = blink_q;
    hex_d      = 6'd0;
    blank_d    = 1'b0;
    src_d      = 2'd0;
    speed_ok_s = bus.i_speed_vld && (bus.i_speed >= 4'd1) && (bus.i_speed <= 4'd8);

    case (bus.i_mode)
      2'd0:    target_s = S_IDLE;
      2'd1:    target_s = S_TIME;
      2'd2:    target_s = S_TIME;
      2'd3:    target_s = S_PAUSE_ON;
      default: target_s = S_IDLE;
    endcase

    if (speed_ok_s) begin
      state_d = S_OVERLAY;
      speed_d = bus.i_speed;
      ovl_d   = OVL_LOAD;
      blink_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_OVERLAY: begin
          // Mode is only looked at once the overlay has fully run out.
          if (ovl_q != CNT_ZERO) begin
            ovl_d = ovl_q - CNT_ONE;
          end else begin
            state_d = target_s;
            blink_d = CNT_ZERO;
          end
        end
        S_PAUSE_ON, S_PAUSE_OFF: begin
          if (bus.i_mode == 2'd3) begin
            if (blink_q == BLINK_LAST) begin
              blink_d = CNT_ZERO;
              state_d = (state_q == S_PAUSE_ON) ? S_PAUSE_OFF : S_PAUSE_ON;
            end else begin
              blink_d = blink_q + CNT_ONE;
            end
          end else begin
            state_d = target_s;
            blink_d = CNT_ZERO;
          end
        end
        default: begin
          state_d = target_s;
          blink_d = CNT_ZERO;
        end
      endcase
    end

    case (state_d)
      S_TIME: begin
        if (bus.i_mode == 2'd2) begin
          hex_d = time_val(bus.i_play_sec);
          src_d = 2'd2;
        end else begin
          hex_d = time_val(bus.i_rec_sec);
          src_d = 2'd1;
        end
      end
      S_PAUSE_ON, S_PAUSE_OFF: begin
        hex_d   = time_val(bus.i_play_sec);
        src_d   = 2'd2;
        blank_d = (state_d == S_PAUSE_OFF);
      end
      S_OVERLAY: begin
        hex_d = {2'b00, speed_d};
        src_d = 2'd3;
      end
      default: begin
        hex_d = 6'd0;
        src_d = 2'd0;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      speed_q <= 4'd1;
      ovl_q   <= CNT_ZERO;
      blink_q <= CNT_ZERO;
      hex_q   <= 6'd0;
      blank_q <= 1'b0;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      ovl_q   <= ovl_d;
      blink_q <= blink_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      src_q   <= src_d;
    end
  end

  assign bus.o_hex   = hex_q;
  assign bus.o_blank = blank_q;
  assign bus.o_src   = src_q;

endmodule
